// File: rtl/conv_mac_engine.sv
// conv_mac_engine: multi-cycle 1-D linear convolution, one output element per cycle.
// Operands are taken over a valid/ready start handshake. The result is held until the
// consumer takes it over the res_valid/res_ready handshake.
module conv_mac_engine #(
  parameter int N        = 4,
  parameter int DW       = 5,
  parameter int OW       = 5,
  parameter int SAT_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [N*DW-1:0]       x_in,
  input  logic [N*DW-1:0]       h_in,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [(2*N-1)*OW-1:0] y_out,
  output logic                  sat_flag,
  output logic                  busy
);

  // Accumulator is wide enough for N full products, so it can never overflow.
  localparam int AW = 2*DW + $clog2(N);
  localparam int KW = $clog2(2*N-1);
  // Compare width covers both the accumulator and the output range.
  localparam int XW = (AW > OW) ? AW : OW;
  localparam logic [XW:0]   ONE_X = 1;
  localparam logic [XW:0]   LIM_X = (ONE_X << OW) - ONE_X;
  localparam logic [XW-1:0] LIM   = LIM_X[XW-1:0];

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [N*DW-1:0] x_q;
  logic [N*DW-1:0] h_q;
  logic [KW-1:0]   k;
  logic [KW-1:0]   jdx;
  logic [AW-1:0]   acc;
  logic [XW-1:0]   acc_x;
  logic            over;
  logic [OW-1:0]   y_k;
  logic            last_k;
  logic            accept;

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign res_valid   = (state == DONE);
  assign accept      = start_valid && start_ready;
  assign last_k      = (k == KW'(2*N-2));

  // Output element k: one multiplier per signal tap i, paired with kernel tap k-i when it exists.
  always_comb begin
    acc = '0;
    jdx = '0;
    for (int i = 0; i < N; i++) begin
      if ((int'(k) >= i) && ((int'(k) - i) < N)) begin
        jdx = KW'(int'(k) - i);
        acc = acc + AW'(x_q[i*DW +: DW]) * AW'(h_q[jdx*DW +: DW]);
      end
    end
  end

  // Range check and wrap/saturate conversion of the current element.
  always_comb begin
    acc_x = XW'(acc);
    over  = (acc_x > LIM);
    y_k   = ((SAT_MODE != 0) && over) ? LIM[OW-1:0] : acc_x[OW-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode: accept, step through 2N-1 elements, wait for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = COMPUTE;
      COMPUTE: if (last_k)    state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then write one result element per COMPUTE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q      <= '0;
      h_q      <= '0;
      k        <= '0;
      y_out    <= '0;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_q      <= x_in;
            h_q      <= h_in;
            k        <= '0;
            y_out    <= '0;
            sat_flag <= 1'b0;
          end
        end
        COMPUTE: begin
          y_out[k*OW +: OW] <= y_k;
          sat_flag          <= sat_flag | over;
          if (!last_k) k <= k + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine: four engine instances (4-tap wrap/saturate, 8-tap wrap/saturate)
// checked against a direct-summation convolution model, plus hand-computed literals.
module tb_conv_mac_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         sv4, rr4, sv8, rr8;
  logic [19:0]  x4, h4;
  logic [63:0]  x8, h8;
  logic         sr0, sr1, sr2, sr3;
  logic         rv0, rv1, rv2, rv3;
  logic         sf0, sf1, sf2, sf3;
  logic         b0, b1, b2, b3;
  logic [34:0]  y0, y1;
  logic [239:0] y2, y3;

  logic [255:0] e0y, e1y, e2y, e3y;
  bit           e0f, e1f, e2f, e3f;
  bit           inflight4 = 0;
  bit           inflight8 = 0;
  int           total = 0;
  int           bad = 0;
  logic [255:0] lit;

  conv_mac_engine #(.N(4), .DW(5), .OW(5), .SAT_MODE(0)) d0 (
    .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(sr0), .x_in(x4), .h_in(h4),
    .res_valid(rv0), .res_ready(rr4), .y_out(y0), .sat_flag(sf0), .busy(b0));
  conv_mac_engine #(.N(4), .DW(5), .OW(5), .SAT_MODE(1)) d1 (
    .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(sr1), .x_in(x4), .h_in(h4),
    .res_valid(rv1), .res_ready(rr4), .y_out(y1), .sat_flag(sf1), .busy(b1));
  conv_mac_engine #(.N(8), .DW(8), .OW(16), .SAT_MODE(0)) d2 (
    .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr2), .x_in(x8), .h_in(h8),
    .res_valid(rv2), .res_ready(rr8), .y_out(y2), .sat_flag(sf2), .busy(b2));
  conv_mac_engine #(.N(8), .DW(8), .OW(16), .SAT_MODE(1)) d3 (
    .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr3), .x_in(x8), .h_in(h8),
    .res_valid(rv3), .res_ready(rr8), .y_out(y3), .sat_flag(sf3), .busy(b3));

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference convolution: y_k is the sum of x_i*h_j over every pair with i+j == k.
  function automatic logic [255:0] model(input int n, input int dw, input int ow, input bit sat,
                                         input logic [63:0] x, input logic [63:0] h,
                                         output bit flag);
    logic [63:0]  acc, xi, hj, lim, mask, yk;
    logic [255:0] r;
    r    = '0;
    flag = 0;
    mask = (64'd1 << dw) - 64'd1;
    lim  = (64'd1 << ow) - 64'd1;
    for (int k = 0; k < 2*n-1; k++) begin
      acc = 0;
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++)
          if (i + j == k) begin
            xi  = (x >> (i*dw)) & mask;
            hj  = (h >> (j*dw)) & mask;
            acc = acc + xi * hj;
          end
      if (acc > lim) flag = 1;
      yk = (sat && acc > lim) ? lim : (acc & lim);
      r  = r | (256'(yk) << (k*ow));
    end
    return r;
  endfunction

  function automatic logic [255:0] pack5(input int v[7]);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 7; k++) r = r | (256'(v[k]) << (k*5));
    return r;
  endfunction

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every negative edge: handshake flags while busy, and full result whenever res_valid is up.
  always @(negedge clk) begin
    if (rst) begin
      if (inflight4) begin
        check_output("busy_flags4_wrap", 256'({sr0, b0}), 256'(2'b01));
        check_output("busy_flags4_sat", 256'({sr1, b1}), 256'(2'b01));
      end
      if (inflight8) check_output("busy_flags8", 256'({sr2, b2, sr3, b3}), 256'(4'b0101));
      if (rv0) begin
        check_output("y4_wrap", 256'(y0), e0y);
        check_output("sat4_wrap", 256'(sf0), 256'(e0f));
      end
      if (rv1) begin
        check_output("y4_sat", 256'(y1), e1y);
        check_output("sat4_sat", 256'(sf1), 256'(e1f));
      end
      if (rv2) check_output("y8_wrap", {255'(y2), sf2}, {e2y[254:0], e2f});
      if (rv3) check_output("y8_sat", {255'(y3), sf3}, {e3y[254:0], e3f});
    end
  end

  // Drive a 4-tap operand pair: handshake in, check latency, hold in DONE, release.
  task automatic apply_stimulus(input logic [19:0] x, input logic [19:0] h, input int hold,
                                input bit toggle);
    int t;
    t = 0;
    while (!sr0 && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) check_output("ready_timeout4", 256'(sr0), 256'(1));
    sv4 = 1; x4 = x; h4 = h;
    e0y = model(4, 5, 5, 0, 64'(x), 64'(h), e0f);
    e1y = model(4, 5, 5, 1, 64'(x), 64'(h), e1f);
    @(posedge clk); #1;
    inflight4 = 1; sv4 = 0; x4 = 20'($urandom); h4 = 20'($urandom);
    t = 0;
    while (!rv0 && t < 40) begin @(posedge clk); #1; t++; end
    check_output("latency4", 256'(t), 256'(7));
    for (int c = 0; c < hold; c++) begin
      if (toggle) begin sv4 = ~sv4; x4 = 20'($urandom); h4 = 20'($urandom); end
      @(posedge clk); #1;
    end
    rr4 = 1;
    @(posedge clk); #1;
    rr4 = 0; inflight4 = 0;
    check_output("release4", 256'({rv0, sr0, rv1, sr1}), 256'(4'b0101));
  endtask

  // Same sequence for the 8-tap pair.
  task automatic apply_stimulus8(input logic [63:0] x, input logic [63:0] h, input int hold);
    int t;
    t = 0;
    while (!sr2 && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) check_output("ready_timeout8", 256'(sr2), 256'(1));
    sv8 = 1; x8 = x; h8 = h;
    e2y = model(8, 8, 16, 0, x, h, e2f);
    e3y = model(8, 8, 16, 1, x, h, e3f);
    @(posedge clk); #1;
    inflight8 = 1; sv8 = 0; x8 = {$urandom, $urandom}; h8 = {$urandom, $urandom};
    t = 0;
    while (!rv2 && t < 40) begin @(posedge clk); #1; t++; end
    check_output("latency8", 256'(t), 256'(15));
    for (int c = 0; c < hold; c++) begin @(posedge clk); #1; end
    rr8 = 1;
    @(posedge clk); #1;
    rr8 = 0; inflight8 = 0;
    check_output("release8", 256'({rv2, sr2}), 256'(2'b01));
  endtask

  initial begin
    int v[7];
    rst = 1; sv4 = 0; rr4 = 0; sv8 = 0; rr8 = 0;
    x4 = '0; h4 = '0; x8 = '0; h8 = '0;
    #1 rst = 0;
    #12;
    check_output("reset_flags", 256'({sr0, rv0, sf0, b0, sr2, rv2, sf2, b2}), 256'(8'b10001000));
    check_output("reset_y", 256'({y0, y2}), 256'(0));
    @(negedge clk) rst = 1;
    @(posedge clk); #1;

    // Ramp signal against a box kernel.
    apply_stimulus({5'd4, 5'd3, 5'd2, 5'd1}, {4{5'd1}}, 0, 0);
    v = '{1, 3, 6, 10, 9, 7, 4};
    lit = pack5(v);
    check_output("lit_ramp_model", e0y, lit);
    check_output("lit_ramp_flag", 256'(e0f), 256'(0));

    // All-max operands: wrap drops the high bits, saturate clamps, both flag.
    apply_stimulus({4{5'd31}}, {4{5'd31}}, 2, 0);
    v = '{1, 2, 3, 4, 3, 2, 1};
    lit = pack5(v);
    check_output("lit_max_wrap", e0y, lit);
    v = '{31, 31, 31, 31, 31, 31, 31};
    lit = pack5(v);
    check_output("lit_max_sat", e1y, lit);
    check_output("lit_max_flags", 256'({e0f, e1f}), 256'(2'b11));

    // Consumer stall in DONE while start_valid toggles with new operands.
    apply_stimulus({5'd7, 5'd0, 5'd9, 5'd2}, {5'd3, 5'd1, 5'd4, 5'd5}, 5, 1);
    apply_stimulus({5'd1, 5'd30, 5'd2, 5'd17}, {5'd6, 5'd2, 5'd0, 5'd11}, 0, 0);

    // Reset dropped in the middle of COMPUTE.
    sv4 = 1; x4 = {5'd31, 5'd31, 5'd31, 5'd31}; h4 = {5'd31, 5'd31, 5'd31, 5'd31};
    @(posedge clk); #1;
    sv4 = 0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 0;
    #1;
    check_output("async_reset_flags", 256'({rv0, b0, sr0, rv1, b1, sr1}), 256'(6'b001001));
    check_output("async_reset_y", 256'({y0, y1}), 256'(0));
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    apply_stimulus({5'd4, 5'd3, 5'd2, 5'd1}, {4{5'd1}}, 1, 0);
    v = '{1, 3, 6, 10, 9, 7, 4};
    lit = pack5(v);
    check_output("lit_after_reset", e0y, lit);

    // Random 4-tap traffic.
    for (int n = 0; n < 20; n++)
      apply_stimulus(20'($urandom), 20'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

    // 8-tap all-max: centre element wraps to 61448 or clamps to 65535.
    sv8 = 1; x8 = '1; h8 = '1;
    @(posedge clk); #1;
    sv8 = 0; inflight8 = 1;
    e2y = model(8, 8, 16, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, e2f);
    e3y = model(8, 8, 16, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, e3f);
    begin
      int t;
      t = 0;
      while (!rv2 && t < 40) begin @(posedge clk); #1; t++; end
      check_output("lit_latency8", 256'(t), 256'(15));
    end
    check_output("lit_y7_wrap", 256'(y2[7*16 +: 16]), 256'(61448));
    check_output("lit_y7_sat", 256'(y3[7*16 +: 16]), 256'(65535));
    check_output("lit_y0", 256'({y2[15:0], y3[15:0]}), 256'({16'd65025, 16'd65025}));
    check_output("lit_flags8", 256'({sf2, sf3}), 256'(2'b11));
    rr8 = 1;
    @(posedge clk); #1;
    rr8 = 0; inflight8 = 0;

    // Random 8-tap traffic, including small operands that never saturate.
    for (int n = 0; n < 6; n++) begin
      if (n % 2 == 0) apply_stimulus8({$urandom, $urandom}, {$urandom, $urandom}, n);
      else            apply_stimulus8({$urandom, $urandom} & {8{8'h0F}}, {$urandom, $urandom} & {8{8'h0F}}, n);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
